// File: rtl/slice_frame_buffer_pkg.sv
// Shared constants and state encoding for the slice frame buffer.
`timescale 1ns/1ps
package slice_frame_buffer_pkg;
   localparam int SFB_W     = 25;
   localparam int SFB_DEPTH = 64;
   localparam int SFB_AW    = 6;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_FULL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/slice_frame_buffer_slice_mem.sv
// Frame storage: one synchronous write port, one combinational read port.
`timescale 1ns/1ps
module slice_mem #(
   parameter int W     = 25,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/slice_frame_buffer.sv
// Loads one frame of slices in arrival order, then replays it to the encoder
// from index DEPTH-1 down to 0 over a valid/ready handshake.
`timescale 1ns/1ps
module slice_frame_buffer
   import slice_frame_buffer_pkg::*;
#(
   parameter int W     = SFB_W,
   parameter int DEPTH = SFB_DEPTH,
   parameter int AW    = SFB_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_slice,
   input  logic          rd_start,
   output logic          frame_full,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_slice,
   output logic [AW-1:0] out_idx,
   output logic          out_last,
   output logic          frame_done,
   output logic [AW:0]   fill_cnt,
   output logic [1:0]    dbg_state
);
   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; out_valid/out_slice/out_idx stay stable until that edge.
   state_t        state, next_state;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW-1:0] mem_raddr;
   logic [W-1:0]  mem_rdata;
   logic          do_write, do_start, do_accept, do_finish;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_LOAD;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      do_write   = 1'b0;
      do_start   = 1'b0;
      do_accept  = 1'b0;
      do_finish  = 1'b0;
      case (state)
         ST_LOAD: begin
            if (in_valid) begin
               do_write = 1'b1;
               if (wr_ptr == AW'(DEPTH - 1)) next_state = ST_FULL;
            end
         end
         ST_FULL: begin
            if (rd_start) begin
               do_start   = 1'b1;
               next_state = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (out_ready) begin
               if (rd_ptr == '0) begin
                  do_finish  = 1'b1;
                  next_state = ST_LOAD;
               end else begin
                  do_accept = 1'b1;
               end
            end
         end
         default: next_state = ST_LOAD;
      endcase
      if (clr) begin
         next_state = ST_LOAD;
         do_write   = 1'b0;
         do_start   = 1'b0;
         do_accept  = 1'b0;
         do_finish  = 1'b0;
      end
   end

   // In FULL the read port pre-fetches the top slice; in DRAIN it looks one ahead.
   assign mem_raddr = (state == ST_FULL) ? AW'(DEPTH - 1) : rd_ptr - 1'b1;

   slice_mem #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (do_write),
      .waddr (wr_ptr),
      .wdata (in_slice),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_cnt   <= '0;
         out_slice  <= '0;
         out_valid  <= 1'b0;
         frame_full <= 1'b0;
         frame_done <= 1'b0;
      end else if (clr) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_cnt   <= '0;
         out_slice  <= '0;
         out_valid  <= 1'b0;
         frame_full <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= do_finish;
         if (do_write) begin
            fill_cnt <= fill_cnt + 1'b1;
            // Pointer parks on the last slot; the state change ends the frame.
            if (wr_ptr == AW'(DEPTH - 1)) frame_full <= 1'b1;
            else                          wr_ptr     <= wr_ptr + 1'b1;
         end
         if (do_start) begin
            frame_full <= 1'b0;
            rd_ptr     <= AW'(DEPTH - 1);
            out_slice  <= mem_rdata;
            out_valid  <= 1'b1;
         end
         if (do_accept) begin
            rd_ptr    <= rd_ptr - 1'b1;
            out_slice <= mem_rdata;
            fill_cnt  <= fill_cnt - 1'b1;
         end
         if (do_finish) begin
            out_valid <= 1'b0;
            fill_cnt  <= '0;
            wr_ptr    <= '0;
         end
      end
   end

   assign in_ready  = (state == ST_LOAD);
   assign out_last  = (state == ST_DRAIN) && (rd_ptr == '0);
   assign out_idx   = rd_ptr;
   assign dbg_state = state;
endmodule

// File: tb/tb_slice_frame_buffer.sv
// Directed bench for slice_frame_buffer: load, replay, stall, clear and reset scenarios.
`timescale 1ns/1ps
module tb_slice_frame_buffer;
   localparam int W = 25;
   localparam int DEPTH = 64;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst, clr, in_valid, rd_start, out_ready;
   logic [W-1:0]  in_slice;
   logic          in_ready, frame_full, out_valid, out_last, frame_done;
   logic [W-1:0]  out_slice;
   logic [AW-1:0] out_idx;
   logic [AW:0]   fill_cnt;
   logic [1:0]    dbg_state;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   slice_frame_buffer dut (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_slice(in_slice),
      .rd_start(rd_start), .frame_full(frame_full),
      .out_valid(out_valid), .out_ready(out_ready), .out_slice(out_slice),
      .out_idx(out_idx), .out_last(out_last), .frame_done(frame_done),
      .fill_cnt(fill_cnt), .dbg_state(dbg_state)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int base);
      in_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         in_slice = W'(base + i);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic start_replay();
      rd_start = 1'b1;
      step();
      rd_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; rd_start = 1'b0; out_ready = 1'b0; in_slice = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      vectors++; if (fill_cnt !== 7'd0) begin miscompares++; $display("FAIL reset_fill: got %0d want 0", fill_cnt); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      vectors++; if (frame_full !== 1'b0) begin miscompares++; $display("FAIL reset_frame_full: got %b want 0", frame_full); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
   endtask

   task automatic test_async_reset();
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_slice = W'(i + 1);
         step();
      end
      in_valid = 1'b0;
      vectors++; if (fill_cnt !== 7'd10) begin miscompares++; $display("FAIL arst_pre_fill: got %0d want 10", fill_cnt); end
      rst = 1'b1;
      #2;
      vectors++; if (fill_cnt !== 7'd0) begin miscompares++; $display("FAIL arst_fill: got %0d want 0", fill_cnt); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_in_ready: got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_out_valid: got %b want 0", out_valid); end
      #1;
      rst = 1'b0;
      step();
   endtask

   task automatic test_fill();
      in_valid = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         in_slice = W'(i + 1);
         step();
         if (i < DEPTH) begin
            vectors++; if (fill_cnt !== 7'(i + 1)) begin miscompares++; $display("FAIL fill_cnt[%0d]: got %0d want %0d", i, fill_cnt, i + 1); end
         end
         if (i == DEPTH - 2) begin
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_63: got %b want 1", in_ready); end
         end
         if (i == DEPTH - 1) begin
            vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready_64: got %b want 0", in_ready); end
            vectors++; if (frame_full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", frame_full); end
         end
      end
      in_valid = 1'b0;
      vectors++; if (fill_cnt !== 7'd64) begin miscompares++; $display("FAIL fill_drop65: got %0d want 64", fill_cnt); end
      vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL fill_state: got %0d want 1", dbg_state); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fill_no_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_drain();
      out_ready = 1'b1;
      start_replay();
      for (int k = DEPTH - 1; k >= 0; k--) begin
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL drain_valid[%0d]: got %b want 1", k, out_valid); end
         vectors++; if (out_idx !== AW'(k)) begin miscompares++; $display("FAIL drain_idx: got %0d want %0d", out_idx, k); end
         vectors++; if (out_slice !== W'(k + 1)) begin miscompares++; $display("FAIL drain_slice[%0d]: got %0h want %0h", k, out_slice, k + 1); end
         vectors++; if (out_last !== (k == 0)) begin miscompares++; $display("FAIL drain_last[%0d]: got %b want %b", k, out_last, k == 0); end
         vectors++; if (fill_cnt !== 7'(k + 1)) begin miscompares++; $display("FAIL drain_fill[%0d]: got %0d want %0d", k, fill_cnt, k + 1); end
         vectors++; if (frame_done !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_early_done[%0d]: got done=%b rdy=%b want 0 0", k, frame_done, in_ready); end
         step();
      end
      out_ready = 1'b0;
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL drain_done: got %b want 1", frame_done); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_in_ready: got %b want 1", in_ready); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL drain_valid_end: got %b want 0", out_valid); end
      vectors++; if (fill_cnt !== 7'd0) begin miscompares++; $display("FAIL drain_fill_end: got %0d want 0", fill_cnt); end
      step();
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL drain_done_pulse: got %b want 0", frame_done); end
   endtask

   task automatic test_stall();
      int exp_idx;
      int cyc;
      bit done;
      load_frame(100);
      start_replay();
      exp_idx = DEPTH - 1;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 400) begin
         vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 1", cyc, out_valid); end
         vectors++; if (out_idx !== AW'(exp_idx)) begin miscompares++; $display("FAIL stall_idx[%0d]: got %0d want %0d", cyc, out_idx, exp_idx); end
         vectors++; if (out_slice !== W'(100 + exp_idx)) begin miscompares++; $display("FAIL stall_slice[%0d]: got %0h want %0h", cyc, out_slice, 100 + exp_idx); end
         out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
         step();
         if (out_ready) begin
            if (exp_idx == 0) done = 1'b1;
            else exp_idx--;
         end
         cyc++;
      end
      out_ready = 1'b0;
      vectors++; if (!done) begin miscompares++; $display("FAIL stall_timeout: got idx %0d want drained", exp_idx); end
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL stall_done: got %b want 1", frame_done); end
      step();
   endtask

   task automatic test_early_start();
      in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         in_slice = W'(i);
         step();
      end
      in_valid = 1'b0;
      start_replay();
      step();
      vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL early_state: got %0d want 0", dbg_state); end
      vectors++; if (fill_cnt !== 7'd30) begin miscompares++; $display("FAIL early_fill: got %0d want 30", fill_cnt); end
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL early_valid: got %b want 0", out_valid); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL early_ready: got %b want 1", in_ready); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      vectors++; if (fill_cnt !== 7'd0) begin miscompares++; $display("FAIL early_clr_fill: got %0d want 0", fill_cnt); end
   endtask

   task automatic test_clr_mid_drain();
      load_frame(200);
      out_ready = 1'b1;
      start_replay();
      while (out_idx != AW'(40) && out_valid) step();
      vectors++; if (out_slice !== W'(240)) begin miscompares++; $display("FAIL clr_pre_slice: got %0h want %0h", out_slice, 240); end
      clr = 1'b1;
      step();
      clr = 1'b0;
      out_ready = 1'b0;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL clr_valid: got %b want 0", out_valid); end
      vectors++; if (fill_cnt !== 7'd0) begin miscompares++; $display("FAIL clr_fill: got %0d want 0", fill_cnt); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL clr_done: got %b want 0", frame_done); end
      vectors++; if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin miscompares++; $display("FAIL clr_state: got rdy=%b st=%0d want 1 0", in_ready, dbg_state); end
      step();
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL clr_done_late: got %b want 0", frame_done); end
      load_frame(500);
      vectors++; if (frame_full !== 1'b1 || fill_cnt !== 7'd64) begin miscompares++; $display("FAIL reload_full: got full=%b fill=%0d want 1 64", frame_full, fill_cnt); end
      out_ready = 1'b1;
      start_replay();
      for (int k = DEPTH - 1; k >= 0; k--) begin
         vectors++; if (out_valid !== 1'b1 || out_idx !== AW'(k) || out_slice !== W'(500 + k)) begin
            miscompares++;
            $display("FAIL reload_out[%0d]: got v=%b idx=%0d s=%0h want 1 %0d %0h", k, out_valid, out_idx, out_slice, k, 500 + k);
         end
         step();
      end
      out_ready = 1'b0;
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL reload_done: got %b want 1", frame_done); end
      step();
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_fill();
      test_drain();
      test_stall();
      test_early_start();
      test_clr_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
